// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nn_pkg
//  Description : Shared definitions for the neuron sequencer: layer codes,
//                FSM state encoding, default layer sizes, address widths and
//                the weight-memory base-address helper.
//  Revision    : 1.0  initial release
// ============================================================================
package nn_pkg;

  // Layer select codes as presented on layer_sel
  typedef enum logic [1:0] {
    LAYER_H1  = 2'd0,
    LAYER_H2  = 2'd1,
    LAYER_OUT = 2'd2,
    LAYER_INV = 2'd3
  } layer_e;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Default network geometry
  localparam int H1_IN_DEF   = 62;
  localparam int H1_OUT_DEF  = 30;
  localparam int H2_IN_DEF   = 30;
  localparam int H2_OUT_DEF  = 30;
  localparam int O_IN_DEF    = 30;
  localparam int O_OUT_DEF   = 10;
  localparam int MAC_LAT_DEF = 2;

  // Address / counter widths
  localparam int IN_ADDR_W  = 7;
  localparam int W_ADDR_W   = 12;
  localparam int OUT_ADDR_W = 5;
  localparam int DRAIN_W    = 4;

  // Weight words are packed layer after layer: hidden-1, hidden-2, output.
  function automatic logic [W_ADDR_W-1:0] layer_base(input layer_e layer,
                                                     input int     h1_words,
                                                     input int     h2_words);
    logic [W_ADDR_W-1:0] base;
    base = '0;
    case (layer)
      LAYER_H2:  base = W_ADDR_W'(h1_words);
      LAYER_OUT: base = W_ADDR_W'(h1_words + h2_words);
      default:   base = '0;
    endcase
    return base;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nseq_counter.sv
`default_nettype none
// ============================================================================
//  Module      : nseq_counter
//  Description : Loadable up-counter with terminal-count flag.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                load_i          - load load_val_i (priority over inc_i)
//                load_val_i      - value to load
//                inc_i           - increment by one
//                term_i          - terminal value
//                count_o         - current count
//                tc_o            - count_o == term_i
//  Revision    : 1.0  initial release
// ============================================================================
module nseq_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] term_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == term_i);

endmodule
`default_nettype wire

// File: rtl/neuron_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_sequencer
//  Description : Control sequencer for one fully-connected layer. For each
//                neuron n it clears the accumulator, streams NUM_IN
//                input/weight address pairs to the MAC, waits out the MAC
//                pipeline, then writes the result (ReLU on hidden layers).
//  Ports       : clk, rst_n        - clock, async active-low reset
//                start, layer_sel  - layer request (sampled in IDLE)
//                in_addr, w_addr   - input-vector / weight read addresses
//                acc_clr, mac_en   - MAC accumulator control
//                act_en, out_wr    - activation enable / result write
//                out_addr          - neuron index being written
//                busy              - not IDLE
//                calculation_done  - one-cycle layer-complete pulse
//  Revision    : 1.0  initial release
// ============================================================================
module neuron_sequencer
  import nn_pkg::*;
#(
  parameter int H1_IN   = H1_IN_DEF,
  parameter int H1_OUT  = H1_OUT_DEF,
  parameter int H2_IN   = H2_IN_DEF,
  parameter int H2_OUT  = H2_OUT_DEF,
  parameter int O_IN    = O_IN_DEF,
  parameter int O_OUT   = O_OUT_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            layer_sel,
  output logic [IN_ADDR_W-1:0]  in_addr,
  output logic [W_ADDR_W-1:0]   w_addr,
  output logic                  acc_clr,
  output logic                  mac_en,
  output logic                  act_en,
  output logic                  out_wr,
  output logic [OUT_ADDR_W-1:0] out_addr,
  output logic                  busy,
  output logic                  calculation_done
);

  localparam int H1_WORDS = H1_IN * H1_OUT;
  localparam int H2_WORDS = H2_IN * H2_OUT;

  state_e               state_q, state_d;
  layer_e               layer_q, layer_d;
  layer_e               layer_sel_e;
  logic [W_ADDR_W-1:0]  wptr_q, wptr_d;

  logic                  i_load, i_inc, i_tc;
  logic [IN_ADDR_W-1:0]  i_cnt, i_term;
  logic                  n_load, n_inc, n_tc;
  logic [OUT_ADDR_W-1:0] n_cnt, n_term;
  logic                  d_load, d_inc, d_tc;
  logic [DRAIN_W-1:0]    d_cnt;

  assign layer_sel_e = layer_e'(layer_sel);

  // Per-layer geometry, driven from the latched layer only
  always_comb begin
    i_term = '0;
    n_term = '0;
    case (layer_q)
      LAYER_H2: begin
        i_term = IN_ADDR_W'(H2_IN - 1);
        n_term = OUT_ADDR_W'(H2_OUT - 1);
      end
      LAYER_OUT: begin
        i_term = IN_ADDR_W'(O_IN - 1);
        n_term = OUT_ADDR_W'(O_OUT - 1);
      end
      default: begin
        i_term = IN_ADDR_W'(H1_IN - 1);
        n_term = OUT_ADDR_W'(H1_OUT - 1);
      end
    endcase
  end

  nseq_counter #(.WIDTH(IN_ADDR_W)) u_i_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (i_load),
    .load_val_i ('0),
    .inc_i      (i_inc),
    .term_i     (i_term),
    .count_o    (i_cnt),
    .tc_o       (i_tc)
  );

  nseq_counter #(.WIDTH(OUT_ADDR_W)) u_n_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (n_load),
    .load_val_i ('0),
    .inc_i      (n_inc),
    .term_i     (n_term),
    .count_o    (n_cnt),
    .tc_o       (n_tc)
  );

  nseq_counter #(.WIDTH(DRAIN_W)) u_drain_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (d_load),
    .load_val_i ('0),
    .inc_i      (d_inc),
    .term_i     (DRAIN_W'(MAC_LAT - 1)),
    .count_o    (d_cnt),
    .tc_o       (d_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      layer_q <= LAYER_H1;
      wptr_q  <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      wptr_q  <= wptr_d;
    end
  end

  // The weight pointer is not advanced on the last MAC beat so that w_addr
  // keeps showing the last address read through DRAIN/WRITE; the missing
  // step is taken when WRITE hands over to the next neuron's CLEAR.
  always_comb begin
    state_d          = state_q;
    layer_d          = layer_q;
    wptr_d           = wptr_q;
    i_load           = 1'b0;
    i_inc            = 1'b0;
    n_load           = 1'b0;
    n_inc            = 1'b0;
    d_load           = 1'b0;
    d_inc            = 1'b0;
    acc_clr          = 1'b0;
    mac_en           = 1'b0;
    act_en           = 1'b0;
    out_wr           = 1'b0;
    calculation_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (layer_sel_e != LAYER_INV)) begin
          layer_d = layer_sel_e;
          n_load  = 1'b1;
          wptr_d  = layer_base(layer_sel_e, H1_WORDS, H2_WORDS);
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        acc_clr = 1'b1;
        i_load  = 1'b1;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        mac_en = 1'b1;
        if (i_tc) begin
          d_load  = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          i_inc  = 1'b1;
          wptr_d = wptr_q + W_ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (d_tc) begin
          state_d = ST_WRITE;
        end else begin
          d_inc = 1'b1;
        end
      end
      ST_WRITE: begin
        out_wr = 1'b1;
        act_en = (layer_q != LAYER_OUT);
        if (n_tc) begin
          state_d = ST_DONE;
        end else begin
          n_inc   = 1'b1;
          wptr_d  = wptr_q + W_ADDR_W'(1);
          state_d = ST_CLEAR;
        end
      end
      ST_DONE: begin
        calculation_done = 1'b1;
        state_d          = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_addr  = i_cnt;
  assign out_addr = n_cnt;
  assign w_addr   = wptr_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_neuron_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_neuron_sequencer
//  Description : Self-checking bench for neuron_sequencer. Expected neuron
//                writes and completion edges are queued when a layer is
//                launched and consumed as the sequencer produces them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_neuron_sequencer;

  localparam int MAC_LAT = 2;

  typedef struct {
    int n;
    int act;
    int w0;
    int nin;
  } exp_wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  layer_sel;
  logic [6:0]  in_addr;
  logic [11:0] w_addr;
  logic        acc_clr;
  logic        mac_en;
  logic        act_en;
  logic        out_wr;
  logic [4:0]  out_addr;
  logic        busy;
  logic        calculation_done;

  exp_wr_t expq[$];
  int      doneq[$];

  int cyc      = 0;
  int n_total  = 0;
  int n_bad    = 0;
  int mac_cnt  = 0;
  int done_cnt = 0;

  neuron_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .layer_sel        (layer_sel),
    .in_addr          (in_addr),
    .w_addr           (w_addr),
    .acc_clr          (acc_clr),
    .mac_en           (mac_en),
    .act_en           (act_en),
    .out_wr           (out_wr),
    .out_addr         (out_addr),
    .busy             (busy),
    .calculation_done (calculation_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int nin_of(input int l);
    return (l == 0) ? 62 : 30;
  endfunction

  function automatic int nout_of(input int l);
    return (l == 2) ? 10 : 30;
  endfunction

  function automatic int base_of(input int l);
    return (l == 0) ? 0 : ((l == 1) ? 1860 : 2760);
  endfunction

  // Output monitor / scoreboard consumer
  always @(negedge clk) begin : mon
    exp_wr_t e;
    if (rst_n) begin
      if (!busy)
        check("idle_strobes", {acc_clr, mac_en, out_wr, act_en, calculation_done}, 0);
      check("act_outside_write", act_en & ~out_wr, 0);
      if (acc_clr) mac_cnt = 0;
      if (mac_en) begin
        if (expq.size() == 0) begin
          check("unexp_mac", mac_en, 0);
        end else begin
          check("in_addr", in_addr, mac_cnt);
          check("w_addr", w_addr, expq[0].w0 + mac_cnt);
        end
        mac_cnt++;
      end
      if (out_wr) begin
        if (expq.size() == 0) begin
          check("unexp_wr", out_wr, 0);
        end else begin
          e = expq.pop_front();
          check("out_addr", out_addr, e.n);
          check("act_en", act_en, e.act);
          check("mac_per_neuron", mac_cnt, e.nin);
        end
      end
      if (calculation_done) begin
        done_cnt++;
        if (doneq.size() == 0) begin
          check("unexp_done", calculation_done, 0);
        end else begin
          // pulse is sampled by the consumer on the next rising edge
          check("done_edge", cyc + 1, doneq.pop_front());
          check("wr_left", expq.size(), 0);
        end
      end
    end
  end

  // Called at negedge+1; the next rising edge samples start.
  task automatic launch(input int l);
    int nin;
    int nout;
    nin  = nin_of(l);
    nout = nout_of(l);
    for (int n = 0; n < nout; n++)
      expq.push_back('{n, (l != 2) ? 1 : 0, base_of(l) + n * nin, nin});
    doneq.push_back(cyc + 1 + 1 + nout * (nin + MAC_LAT + 2));
    layer_sel = 2'(l);
    start     = 1'b1;
    @(negedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int target;
    target = done_cnt + 1;
    for (int k = 0; k < budget && done_cnt < target; k++) begin
      @(negedge clk); #1;
    end
    check("done_seen", done_cnt, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    layer_sel = 2'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_strobes", {acc_clr, mac_en, out_wr, act_en, calculation_done}, 0);
    check("rst_in_addr", in_addr, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_out_addr", out_addr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    // Output layer
    launch(2);
    check("busy_run", busy, 1);
    wait_done(500);
    check("hold_in_addr_o", in_addr, 29);
    check("hold_w_addr_o", w_addr, 3059);
    check("hold_out_addr_o", out_addr, 9);
    @(negedge clk); #1;
    check("idle_after_o", busy, 0);

    // Hidden-1
    launch(0);
    wait_done(2500);
    check("hold_w_addr_h1", w_addr, 1859);
    check("hold_in_addr_h1", in_addr, 61);
    check("hold_out_addr_h1", out_addr, 29);
    @(negedge clk); #1;

    // Hidden-2
    launch(1);
    wait_done(1500);
    check("hold_w_addr_h2", w_addr, 2759);
    @(negedge clk); #1;

    // Invalid layer code
    layer_sel = 2'd3;
    start     = 1'b1;
    @(negedge clk); #1;
    start     = 1'b0;
    for (int k = 0; k < 20; k++) begin
      check("inv_busy", busy, 0);
      @(negedge clk); #1;
    end

    // Reset in the middle of neuron 5 of hidden-1
    launch(0);
    for (int k = 0; k < 2000; k++) begin
      if (mac_en && out_addr == 5 && in_addr == 10) break;
      @(negedge clk); #1;
    end
    check("reach_n5", {out_addr, in_addr}, {5'd5, 7'd10});
    rst_n = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_strobes", {acc_clr, mac_en, out_wr, act_en, calculation_done}, 0);
    check("async_in_addr", in_addr, 0);
    check("async_w_addr", w_addr, 0);
    check("async_out_addr", out_addr, 0);
    expq.delete();
    doneq.delete();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("post_rst_busy", busy, 0);
    launch(0);
    wait_done(2500);
    @(negedge clk); #1;

    // Restart attempts while busy and in DONE
    launch(2);
    layer_sel = 2'd0;
    start     = 1'b1;
    repeat (50) @(negedge clk);
    #1;
    start = 1'b0;
    wait_done(500);
    layer_sel = 2'd0;
    start     = 1'b1;
    @(negedge clk); #1;
    start     = 1'b0;
    check("done_restart_ignored", busy, 0);
    repeat (5) @(negedge clk);
    #1;
    check("still_idle", busy, 0);
    check("held_out_addr", out_addr, 9);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
